hilo_mul_unit: RTL and testbench

//   Sequential control and HI/LO result store around the combinational 32x32 signed multiplier.

---
 rtl/hilo_mul_unit.sv | 141 ++++++++++++++
 tb/tb_hilo_mul_unit.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hilo_mul_unit.sv
// hilo_mul_unit: issue control and HI/LO result store around an external
// combinational 32x32 signed multiplier. Operands are held stable on
// mul_a/mul_b for MUL_CYCLES clocks. The product is then written into HI/LO.
// Unsigned products get a fix-up term because the multiplier is always signed.
module hilo_mul_unit #(
    parameter int MUL_CYCLES = 4  // legal range 1..15
) (
    input  logic        clk,
    input  logic        reset,    // synchronous, active-low
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    input  logic        rd_hi,
    input  logic        rd_lo,
    output logic [31:0] mul_a,
    output logic [31:0] mul_b,
    input  logic [63:0] mul_z,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] rdata,
    output logic        busy,
    output logic        done,
    output logic        stall
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam logic [3:0] CNT_INIT = 4'(MUL_CYCLES);

    state_t      state;
    state_t      state_next;
    logic [3:0]  cnt;
    logic        is_unsigned;
    logic        accept_mul;
    logic        write_hi;
    logic        write_lo;
    logic        finish_mul;
    logic [63:0] fix_a;
    logic [63:0] fix_b;
    logic [63:0] product;

    // State register; reset discards any in-flight multiply.
    always_ff @(posedge clk) begin
        // NOTE: sequential state always uses non-blocking assignments so every
        // flop samples pre-edge values regardless of block ordering.
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode and per-edge action strobes.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a signal unassigned and no latch is inferred.
        state_next = state;
        accept_mul = 1'b0;
        write_hi   = 1'b0;
        write_lo   = 1'b0;
        finish_mul = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (!op[1]) begin
                        accept_mul = 1'b1;
                        state_next = BUSY;
                    end else if (op[0]) begin
                        write_lo = 1'b1;
                    end else begin
                        write_hi = 1'b1;
                    end
                end
            end
            BUSY: begin
                // Requests arriving here are ignored; stall tells the pipeline to retry.
                if (cnt == 4'd1) begin
                    finish_mul = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Unsigned correction: a signed product treats a set top bit as -2^31.
    // Adding the other operand shifted up by 32 restores the unsigned value mod 2^64.
    always_comb begin
        fix_a   = mul_a[31] ? {mul_b, 32'b0} : 64'd0;
        fix_b   = mul_b[31] ? {mul_a, 32'b0} : 64'd0;
        product = is_unsigned ? (mul_z + fix_a + fix_b) : mul_z;
    end

    // Operand capture, cycle counter, HI/LO writes and the done pulse.
    always_ff @(posedge clk) begin
        // NOTE: these are plain registers rather than a memory array, so all of
        // them are cleared by reset.
        if (!reset) begin
            mul_a       <= 32'd0;
            mul_b       <= 32'd0;
            is_unsigned <= 1'b0;
            cnt         <= 4'd0;
            hi          <= 32'd0;
            lo          <= 32'd0;
            done        <= 1'b0;
        end else begin
            done <= 1'b0;
            if (accept_mul) begin
                mul_a       <= rs_data;
                mul_b       <= rt_data;
                is_unsigned <= op[0];
                cnt         <= CNT_INIT;
            end else if (state == BUSY) begin
                cnt <= cnt - 4'd1;
            end
            if (write_hi) begin
                hi <= rs_data;
            end
            if (write_lo) begin
                lo <= rs_data;
            end
            if (finish_mul) begin
                hi   <= product[63:32];
                lo   <= product[31:0];
                done <= 1'b1;
            end
        end
    end

    // Read port and pipeline hold.
    always_comb begin
        busy  = (state == BUSY);
        rdata = rd_hi ? hi : lo;
        stall = busy & (start | rd_hi | rd_lo);
    end

endmodule

// File: tb/tb_hilo_mul_unit.sv
// Self-checking bench for hilo_mul_unit. A table of directed vectors covers
// the main operations, and hand-written sequences cover stall, back-to-back
// issue, reset abort and the MUL_CYCLES=1 case.
module tb_hilo_mul_unit;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
    } vec_t;

    logic        clk;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        rd_hi;
    logic        rd_lo;
    logic [31:0] mul_a;
    logic [31:0] mul_b;
    logic [63:0] mul_z;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] rdata;
    logic        busy;
    logic        done;
    logic        stall;

    // Second instance with MUL_CYCLES=1.
    logic        start1;
    logic [31:0] mul_a1;
    logic [31:0] mul_b1;
    logic [63:0] mul_z1;
    logic [31:0] hi1;
    logic [31:0] lo1;
    logic [31:0] rdata1;
    logic        busy1;
    logic        done1;
    logic        stall1;

    int total;
    int bad;

    hilo_mul_unit #(.MUL_CYCLES(4)) u_dut (
        .clk(clk), .reset(reset), .start(start), .op(op),
        .rs_data(rs_data), .rt_data(rt_data), .rd_hi(rd_hi), .rd_lo(rd_lo),
        .mul_a(mul_a), .mul_b(mul_b), .mul_z(mul_z),
        .hi(hi), .lo(lo), .rdata(rdata),
        .busy(busy), .done(done), .stall(stall)
    );

    hilo_mul_unit #(.MUL_CYCLES(1)) u_dut1 (
        .clk(clk), .reset(reset), .start(start1), .op(2'b00),
        .rs_data(32'd7), .rt_data(32'd9), .rd_hi(1'b0), .rd_lo(1'b0),
        .mul_a(mul_a1), .mul_b(mul_b1), .mul_z(mul_z1),
        .hi(hi1), .lo(lo1), .rdata(rdata1),
        .busy(busy1), .done(done1), .stall(stall1)
    );

    // Combinational signed multiplier models.
    assign mul_z  = $signed(mul_a)  * $signed(mul_b);
    assign mul_z1 = $signed(mul_a1) * $signed(mul_b1);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wait for busy to drop, counting busy cycles (bounded), after the start edge.
    task automatic wait_idle(output int cycles);
        cycles = 0;
        while (busy && cycles < 20) begin
            cycles++;
            tick();
        end
    endtask

    vec_t vecs[10];
    int   nb;

    initial begin
        total   = 0;
        bad     = 0;
        reset   = 1'b0;
        start   = 1'b0;
        start1  = 1'b0;
        op      = 2'b00;
        rs_data = 32'd0;
        rt_data = 32'd0;
        rd_hi   = 1'b0;
        rd_lo   = 1'b0;

        vecs[0] = '{2'b00, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFE};
        vecs[1] = '{2'b01, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 32'hFFFFFFFE};
        vecs[2] = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
        vecs[3] = '{2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001};
        vecs[4] = '{2'b10, 32'h12345678, 32'h0,        32'h12345678, 32'h00000001};
        vecs[5] = '{2'b11, 32'h9ABCDEF0, 32'h0,        32'h12345678, 32'h9ABCDEF0};
        vecs[6] = '{2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
        vecs[7] = '{2'b01, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
        vecs[8] = '{2'b01, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000};
        vecs[9] = '{2'b00, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1};

        // Reset state.
        tick();
        tick();
        check("reset_hi",    64'(hi),    64'd0);
        check("reset_lo",    64'(lo),    64'd0);
        check("reset_mul_a", 64'(mul_a), 64'd0);
        check("reset_mul_b", 64'(mul_b), 64'd0);
        check("reset_busy",  64'(busy),  64'd0);
        check("reset_done",  64'(done),  64'd0);
        check("reset_stall", 64'(stall), 64'd0);
        reset = 1'b1;
        tick();

        // Table-driven operations.
        for (int i = 0; i < 10; i++) begin
            start   = 1'b1;
            op      = vecs[i].op;
            rs_data = vecs[i].rs;
            rt_data = vecs[i].rt;
            tick();
            start = 1'b0;
            if (!vecs[i].op[1]) begin
                check($sformatf("v%0d_mul_a", i), 64'(mul_a), 64'(vecs[i].rs));
                check($sformatf("v%0d_mul_b", i), 64'(mul_b), 64'(vecs[i].rt));
                wait_idle(nb);
                check($sformatf("v%0d_busy_cycles", i), 64'(nb), 64'd4);
                check($sformatf("v%0d_done", i), 64'(done), 64'd1);
            end else begin
                check($sformatf("v%0d_busy", i), 64'(busy), 64'd0);
                check($sformatf("v%0d_done", i), 64'(done), 64'd0);
            end
            check($sformatf("v%0d_hi", i), 64'(hi), 64'(vecs[i].exp_hi));
            check($sformatf("v%0d_lo", i), 64'(lo), 64'(vecs[i].exp_lo));
            tick();
            check($sformatf("v%0d_done_clear", i), 64'(done), 64'd0);
        end

        // Read mux after MTHI/MTLO-like state: set hi/lo again and read.
        start = 1'b1; op = 2'b10; rs_data = 32'h12345678; tick();
        op = 2'b11; rs_data = 32'h9ABCDEF0; tick();
        start = 1'b0;
        rd_hi = 1'b1;
        #1 check("rd_hi_rdata", 64'(rdata), 64'h12345678);
        check("rd_idle_stall", 64'(stall), 64'd0);
        rd_lo = 1'b1;
        #1 check("rd_both_rdata", 64'(rdata), 64'h12345678);
        rd_hi = 1'b0;
        #1 check("rd_lo_rdata", 64'(rdata), 64'h9ABCDEF0);
        rd_lo = 1'b0;
        tick();

        // Stall during busy: reads and a blocked MTHI.
        start = 1'b1; op = 2'b11; rs_data = 32'h11111111; tick();
        op = 2'b00; rs_data = 32'd3; rt_data = 32'd5; tick();
        rd_lo = 1'b1; op = 2'b10; rs_data = 32'hDEADBEEF; rt_data = 32'd0;
        nb = 0;
        while (busy && nb < 20) begin
            #1;
            check($sformatf("stall_c%0d", nb), 64'(stall), 64'd1);
            check($sformatf("stall_rdata_c%0d", nb), 64'(rdata), 64'h11111111);
            check($sformatf("stall_hi_c%0d", nb), 64'(hi), 64'h12345678);
            check($sformatf("stall_mul_a_c%0d", nb), 64'(mul_a), 64'd3);
            nb++;
            tick();
        end
        start = 1'b0; rd_lo = 1'b0;
        check("stall_busy_cycles", 64'(nb), 64'd4);
        check("stall_done", 64'(done), 64'd1);
        check("stall_final_hi", 64'(hi), 64'h00000000);
        check("stall_final_lo", 64'(lo), 64'h0000000F);
        tick();
        check("stall_mthi_dropped", 64'(hi), 64'h00000000);

        // Back-to-back: new multiply issued at the done edge.
        start = 1'b1; op = 2'b00; rs_data = 32'd2; rt_data = 32'd3; tick();
        wait_idle(nb);
        check("b2b_first_done", 64'(done), 64'd1);
        check("b2b_first_lo", 64'(lo), 64'd6);
        rs_data = 32'd4; rt_data = 32'd5; tick();
        start = 1'b0;
        check("b2b_accepted_busy", 64'(busy), 64'd1);
        check("b2b_done_cleared", 64'(done), 64'd0);
        wait_idle(nb);
        check("b2b_busy_cycles", 64'(nb), 64'd4);
        check("b2b_second_lo", 64'(lo), 64'd20);
        check("b2b_second_hi", 64'(hi), 64'd0);
        tick();

        // Reset abort during the 2nd busy cycle.
        start = 1'b1; op = 2'b00; rs_data = 32'd7; rt_data = 32'd9; tick();
        start = 1'b0;
        tick();
        check("abort_busy_before", 64'(busy), 64'd1);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_hi", 64'(hi), 64'd0);
        check("abort_lo", 64'(lo), 64'd0);
        check("abort_mul_a", 64'(mul_a), 64'd0);
        for (int k = 0; k < 5; k++) begin
            tick();
            check($sformatf("abort_no_done_%0d", k), 64'(done), 64'd0);
        end
        check("abort_lo_kept", 64'(lo), 64'd0);

        // MUL_CYCLES=1 instance.
        start1 = 1'b1; tick();
        start1 = 1'b0;
        check("mc1_busy", 64'(busy1), 64'd1);
        tick();
        check("mc1_busy_drop", 64'(busy1), 64'd0);
        check("mc1_done", 64'(done1), 64'd1);
        check("mc1_lo", 64'(lo1), 64'h3F);
        check("mc1_hi", 64'(hi1), 64'd0);
        tick();
        check("mc1_done_clear", 64'(done1), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
